// File: rtl/ddr_port_arb.sv
// ddr_port_arb
//   Two-client burst arbiter in front of a DDR3 controller's write/read FIFO
//   port. One client at a time owns the port for a whole burst. Grants go
//   round-robin. Bursts are counted beat by beat against the length latched
//   at grant time. The arbiter parks in WAIT_INIT until DDR3 calibration is
//   reported done, and it falls back there whenever calibration is lost.
//
// Ports
//   clk_50m, rst          : single clock (rising edge), async active-high reset
//   ddr3_init_done        : calibration done, asynchronous, synchronised here
//   cK_req/cK_wr/cK_len   : client K burst request, direction (1=write), beats
//   cK_wdata              : client K write data, forwarded combinationally
//   cK_gnt                : client K owns the port (WRITE/READ/DRAIN/DONE)
//   cK_pull               : client K write beat consumed this cycle
//   cK_rdata/cK_rvalid    : client K read beat, registered one cycle after rd_en
//   cK_done               : one-cycle burst-complete pulse
//   wr_en/wr_data/wr_full : DDR write FIFO port
//   rd_en/rd_data/rd_empty: DDR read FIFO port (rd_data valid alongside rd_en)
module ddr_port_arb #(
    parameter int DW = 16,
    parameter int LW = 10
) (
    input  logic          clk_50m,
    input  logic          rst,
    input  logic          ddr3_init_done,
    input  logic          c0_req,
    input  logic          c0_wr,
    input  logic [LW-1:0] c0_len,
    input  logic [DW-1:0] c0_wdata,
    output logic          c0_gnt,
    output logic          c0_pull,
    output logic [DW-1:0] c0_rdata,
    output logic          c0_rvalid,
    output logic          c0_done,
    input  logic          c1_req,
    input  logic          c1_wr,
    input  logic [LW-1:0] c1_len,
    input  logic [DW-1:0] c1_wdata,
    output logic          c1_gnt,
    output logic          c1_pull,
    output logic [DW-1:0] c1_rdata,
    output logic          c1_rvalid,
    output logic          c1_done,
    output logic          wr_en,
    output logic [DW-1:0] wr_data,
    input  logic          wr_full,
    output logic          rd_en,
    input  logic [DW-1:0] rd_data,
    input  logic          rd_empty
);

    typedef enum logic [2:0] {
        S_WAIT_INIT = 3'd0,
        S_IDLE      = 3'd1,
        S_WRITE     = 3'd2,
        S_READ      = 3'd3,
        S_DRAIN     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam logic [LW-1:0] LEN_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [LW-1:0] LEN_ZERO = {LW{1'b0}};
    localparam logic [DW-1:0] DAT_ZERO = {DW{1'b0}};

    state_t        r_state;
    state_t        w_next_state;
    logic          r_init_meta;
    logic          r_init;
    logic          r_owner;      // 0 = client 0, 1 = client 1
    logic          r_wr;
    logic [LW-1:0] r_len;
    logic [LW-1:0] r_cnt;
    logic          r_last;       // last client to complete a burst
    logic          r_c0_rvalid;
    logic          r_c1_rvalid;
    logic [DW-1:0] r_c0_rdata;
    logic [DW-1:0] r_c1_rdata;

    logic          w_elig0;
    logic          w_elig1;
    logic          w_pick;
    logic          w_pick_wr;
    logic [LW-1:0] w_pick_len;
    logic          w_grant;
    logic          w_last_beat;
    logic          w_wbeat;
    logic          w_rbeat;
    logic          w_active;
    logic          w_c0_gnt;
    logic          w_c1_gnt;
    logic          w_c0_pull;
    logic          w_c1_pull;
    logic          w_c0_done;
    logic          w_c1_done;
    logic [DW-1:0] w_wr_data;

    // Two-flop synchroniser for the calibration-done flag
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_init_meta <= 1'b0;
            r_init      <= 1'b0;
        end else begin
            r_init_meta <= ddr3_init_done;
            r_init      <= r_init_meta;
        end
    end

    // Eligibility and round-robin pick; zero-length requests are never eligible
    always_comb begin
        w_elig0 = c0_req && (c0_len != LEN_ZERO);
        w_elig1 = c1_req && (c1_len != LEN_ZERO);
        if (w_elig0 && w_elig1) begin
            w_pick = ~r_last;
        end else begin
            w_pick = w_elig1;
        end
        w_pick_wr   = w_pick ? c1_wr  : c0_wr;
        w_pick_len  = w_pick ? c1_len : c0_len;
        w_grant     = (r_state == S_IDLE) && r_init && (w_elig0 || w_elig1);
        w_last_beat = (r_cnt == (r_len - LEN_ONE));
    end

    // FSM state register
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_state <= S_WAIT_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; losing calibration anywhere returns to WAIT_INIT
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT_INIT: begin
                if (r_init) w_next_state = S_IDLE;
                else        w_next_state = S_WAIT_INIT;
            end
            S_IDLE: begin
                if (!r_init)      w_next_state = S_WAIT_INIT;
                else if (w_grant) w_next_state = w_pick_wr ? S_WRITE : S_READ;
                else              w_next_state = S_IDLE;
            end
            S_WRITE: begin
                if (!r_init)                     w_next_state = S_WAIT_INIT;
                else if (w_wbeat && w_last_beat) w_next_state = S_DONE;
                else                             w_next_state = S_WRITE;
            end
            S_READ: begin
                if (!r_init)                     w_next_state = S_WAIT_INIT;
                else if (w_rbeat && w_last_beat) w_next_state = S_DRAIN;
                else                             w_next_state = S_READ;
            end
            S_DRAIN: begin
                if (!r_init) w_next_state = S_WAIT_INIT;
                else         w_next_state = S_DONE;
            end
            S_DONE: begin
                if (!r_init) w_next_state = S_WAIT_INIT;
                else         w_next_state = S_IDLE;
            end
            default: w_next_state = S_WAIT_INIT;
        endcase
    end

    // FSM outputs; every port strobe is also gated by init so an abort is clean
    always_comb begin
        w_wbeat   = (r_state == S_WRITE) && r_wr && r_init && !wr_full;
        w_rbeat   = (r_state == S_READ) && !r_wr && r_init && !rd_empty;
        w_active  = r_init && ((r_state == S_WRITE) || (r_state == S_READ) ||
                               (r_state == S_DRAIN) || (r_state == S_DONE));
        w_c0_gnt  = w_active && !r_owner;
        w_c1_gnt  = w_active && r_owner;
        w_c0_pull = w_wbeat && !r_owner;
        w_c1_pull = w_wbeat && r_owner;
        w_c0_done = r_init && (r_state == S_DONE) && !r_owner;
        w_c1_done = r_init && (r_state == S_DONE) && r_owner;
        if (w_wbeat) begin
            w_wr_data = r_owner ? c1_wdata : c0_wdata;
        end else begin
            w_wr_data = DAT_ZERO;
        end
    end

    // Burst context: owner, direction, length, beat counter, last-granted
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_owner <= 1'b0;
            r_wr    <= 1'b0;
            r_len   <= LEN_ZERO;
            r_cnt   <= LEN_ZERO;
            r_last  <= 1'b1;
        end else begin
            if (w_grant) begin
                r_owner <= w_pick;
                r_wr    <= w_pick_wr;
                r_len   <= w_pick_len;
                r_cnt   <= LEN_ZERO;
            end else if (w_wbeat || w_rbeat) begin
                r_cnt   <= r_cnt + LEN_ONE;
            end else begin
                r_cnt   <= r_cnt;
            end
            // An aborted burst does not count as served
            if ((r_state == S_DONE) && r_init) begin
                r_last <= r_owner;
            end else begin
                r_last <= r_last;
            end
        end
    end

    // Read return path: capture rd_data with rd_en, present it next cycle
    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            r_c0_rvalid <= 1'b0;
            r_c1_rvalid <= 1'b0;
            r_c0_rdata  <= DAT_ZERO;
            r_c1_rdata  <= DAT_ZERO;
        end else begin
            r_c0_rvalid <= w_rbeat && !r_owner;
            r_c1_rvalid <= w_rbeat && r_owner;
            if (w_rbeat && !r_owner) r_c0_rdata <= rd_data;
            else                     r_c0_rdata <= r_c0_rdata;
            if (w_rbeat && r_owner)  r_c1_rdata <= rd_data;
            else                     r_c1_rdata <= r_c1_rdata;
        end
    end

    assign c0_gnt    = w_c0_gnt;
    assign c1_gnt    = w_c1_gnt;
    assign c0_pull   = w_c0_pull;
    assign c1_pull   = w_c1_pull;
    assign c0_done   = w_c0_done;
    assign c1_done   = w_c1_done;
    assign c0_rvalid = r_c0_rvalid;
    assign c1_rvalid = r_c1_rvalid;
    assign c0_rdata  = r_c0_rdata;
    assign c1_rdata  = r_c1_rdata;
    assign wr_en     = w_wbeat;
    assign rd_en     = w_rbeat;
    assign wr_data   = w_wr_data;

endmodule

// File: tb/tb_ddr_port_arb.sv
// Directed bench for ddr_port_arb: init sequencing, write burst, stalled
// read, write stall, round-robin fairness, zero-length masking, init-loss
// abort and asynchronous reset mid-read.
module tb_ddr_port_arb;

    logic        clk_50m = 1'b0;
    logic        rst;
    logic        ddr3_init_done;
    logic        c0_req, c0_wr, c1_req, c1_wr;
    logic [9:0]  c0_len, c1_len;
    logic [15:0] c0_wdata, c1_wdata;
    logic        c0_gnt, c0_pull, c0_rvalid, c0_done;
    logic        c1_gnt, c1_pull, c1_rvalid, c1_done;
    logic [15:0] c0_rdata, c1_rdata;
    logic        wr_en, wr_full, rd_en, rd_empty;
    logic [15:0] wr_data, rd_data;

    int n_vec;
    int n_miss;

    ddr_port_arb #(.DW(16), .LW(10)) dut (
        .clk_50m(clk_50m), .rst(rst), .ddr3_init_done(ddr3_init_done),
        .c0_req(c0_req), .c0_wr(c0_wr), .c0_len(c0_len), .c0_wdata(c0_wdata),
        .c0_gnt(c0_gnt), .c0_pull(c0_pull), .c0_rdata(c0_rdata),
        .c0_rvalid(c0_rvalid), .c0_done(c0_done),
        .c1_req(c1_req), .c1_wr(c1_wr), .c1_len(c1_len), .c1_wdata(c1_wdata),
        .c1_gnt(c1_gnt), .c1_pull(c1_pull), .c1_rdata(c1_rdata),
        .c1_rvalid(c1_rvalid), .c1_done(c1_done),
        .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one clock and step 1 ns past the edge
    task automatic cyc();
        @(posedge clk_50m);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_miss = 0;
        rst = 1'b1; ddr3_init_done = 1'b0;
        c0_req = 1'b0; c0_wr = 1'b0; c0_len = 10'd0; c0_wdata = 16'h0000;
        c1_req = 1'b0; c1_wr = 1'b0; c1_len = 10'd0; c1_wdata = 16'h0000;
        wr_full = 1'b0; rd_empty = 1'b1; rd_data = 16'h0000;

        // ---- reset state
        cyc(); cyc(); #1;
        chk("rst_c0_gnt", c0_gnt, 1'b0);
        chk("rst_c1_gnt", c1_gnt, 1'b0);
        chk("rst_wr_en", wr_en, 1'b0);
        chk("rst_rd_en", rd_en, 1'b0);
        chk("rst_wr_data", wr_data, 16'h0000);
        chk("rst_c0_rvalid", c0_rvalid, 1'b0);
        chk("rst_c0_rdata", c0_rdata, 16'h0000);
        chk("rst_c0_done", c0_done, 1'b0);

        // ---- no grant before calibration
        cyc(); rst = 1'b0; c0_req = 1'b1; c0_wr = 1'b1; c0_len = 10'd4;
        repeat (3) begin
            cyc(); #1;
            chk("preinit_gnt", c0_gnt, 1'b0);
        end
        cyc(); ddr3_init_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(); #1;
            chk("sync_gnt", c0_gnt, 1'b0);
            chk("sync_wr_en", wr_en, 1'b0);
        end

        // ---- c0 write, len 4; request/len/dir changed after grant
        cyc(); c0_req = 1'b0; c0_len = 10'd1; c0_wr = 1'b0; c0_wdata = 16'h00A0; #1;
        chk("wr_gnt", c0_gnt, 1'b1);
        chk("wr_en_b0", wr_en, 1'b1);
        chk("wr_data_b0", wr_data, 16'h00A0);
        chk("wr_pull_b0", c0_pull, 1'b1);
        chk("wr_c1_pull", c1_pull, 1'b0);
        for (int i = 1; i < 4; i++) begin
            cyc(); c0_wdata = 16'h00A0 + 16'(i); #1;
            chk("wr_en_bn", wr_en, 1'b1);
            chk("wr_data_bn", wr_data, 16'h00A0 + 16'(i));
            chk("wr_pull_bn", c0_pull, 1'b1);
            chk("wr_rd_en", rd_en, 1'b0);
        end
        cyc(); #1;
        chk("wr_done", c0_done, 1'b1);
        chk("wr_done_gnt", c0_gnt, 1'b1);
        chk("wr_done_en", wr_en, 1'b0);
        chk("wr_done_data", wr_data, 16'h0000);
        chk("wr_done_pull", c0_pull, 1'b0);

        // ---- c1 read, len 3, rd_empty stall on 2nd beat
        cyc(); c1_req = 1'b1; c1_wr = 1'b0; c1_len = 10'd3; rd_empty = 1'b0; rd_data = 16'd0; #1;
        chk("idle_c0_done", c0_done, 1'b0);
        chk("idle_c0_gnt", c0_gnt, 1'b0);
        cyc(); c1_req = 1'b0; #1;
        chk("rd_gnt", c1_gnt, 1'b1);
        chk("rd_en_b0", rd_en, 1'b1);
        chk("rd_wr_en", wr_en, 1'b0);
        chk("rd_rvalid_0", c1_rvalid, 1'b0);
        cyc(); rd_empty = 1'b1; #1;
        chk("rd_stall_en", rd_en, 1'b0);
        chk("rd_rvalid_b0", c1_rvalid, 1'b1);
        chk("rd_rdata_b0", c1_rdata, 16'd0);
        cyc(); rd_empty = 1'b0; rd_data = 16'd1; #1;
        chk("rd_en_b1", rd_en, 1'b1);
        chk("rd_rvalid_gap", c1_rvalid, 1'b0);
        chk("rd_rdata_hold", c1_rdata, 16'd0);
        cyc(); rd_data = 16'd2; #1;
        chk("rd_en_b2", rd_en, 1'b1);
        chk("rd_rvalid_b1", c1_rvalid, 1'b1);
        chk("rd_rdata_b1", c1_rdata, 16'd1);
        cyc(); rd_empty = 1'b1; #1;
        chk("drain_rd_en", rd_en, 1'b0);
        chk("drain_rvalid", c1_rvalid, 1'b1);
        chk("drain_rdata", c1_rdata, 16'd2);
        chk("drain_done", c1_done, 1'b0);
        chk("drain_gnt", c1_gnt, 1'b1);
        chk("drain_c0_rvalid", c0_rvalid, 1'b0);
        cyc(); #1;
        chk("rd_done", c1_done, 1'b1);
        chk("rd_done_rvalid", c1_rvalid, 1'b0);
        chk("rd_done_rdata", c1_rdata, 16'd2);
        chk("rd_done_c0", c0_done, 1'b0);

        // ---- c1 write, len 2, first cycle blocked by wr_full
        cyc(); c1_req = 1'b1; c1_wr = 1'b1; c1_len = 10'd2; wr_full = 1'b1; c1_wdata = 16'h0055; #1;
        chk("idle2_done", c1_done, 1'b0);
        chk("idle2_gnt", c1_gnt, 1'b0);
        cyc(); #1;
        chk("full_gnt", c1_gnt, 1'b1);
        chk("full_wr_en", wr_en, 1'b0);
        chk("full_wr_data", wr_data, 16'h0000);
        chk("full_pull", c1_pull, 1'b0);
        cyc(); wr_full = 1'b0; c1_wdata = 16'h0066; #1;
        chk("c1w_en_b0", wr_en, 1'b1);
        chk("c1w_data_b0", wr_data, 16'h0066);
        chk("c1w_pull_b0", c1_pull, 1'b1);
        chk("c1w_c0_pull", c0_pull, 1'b0);
        cyc(); c1_wdata = 16'h0077; c1_req = 1'b0; #1;
        chk("c1w_en_b1", wr_en, 1'b1);
        chk("c1w_data_b1", wr_data, 16'h0077);
        cyc(); #1;
        chk("c1w_done", c1_done, 1'b1);

        // ---- fairness: both request len 2 continuously
        cyc(); c0_req = 1'b1; c1_req = 1'b1; c0_len = 10'd2; c1_len = 10'd2;
        c0_wr = 1'b1; c1_wr = 1'b1; #1;
        chk("rr_idle_gnt", c1_gnt, 1'b0);
        for (int b = 0; b < 4; b++) begin
            cyc(); #1;
            chk("rr_c0_gnt", c0_gnt, 1'((b % 2) == 0));
            chk("rr_c1_gnt", c1_gnt, 1'((b % 2) == 1));
            chk("rr_wr_en", wr_en, 1'b1);
            cyc(); #1;
            cyc(); #1;
            chk("rr_c0_done", c0_done, 1'((b % 2) == 0));
            chk("rr_c1_done", c1_done, 1'((b % 2) == 1));
            cyc(); if (b == 3) c0_len = 10'd0; #1;
            chk("rr_idle_c0", c0_gnt, 1'b0);
            chk("rr_idle_c1", c1_gnt, 1'b0);
        end

        // ---- c0 with len 0 is never granted
        for (int b = 0; b < 2; b++) begin
            cyc(); #1;
            chk("len0_c0_gnt", c0_gnt, 1'b0);
            chk("len0_c1_gnt", c1_gnt, 1'b1);
            cyc(); #1;
            cyc(); #1;
            chk("len0_c0_done", c0_done, 1'b0);
            chk("len0_c1_done", c1_done, 1'b1);
            cyc();
            if (b == 1) begin
                c1_req = 1'b0; c0_len = 10'd8; c0_wdata = 16'h0BB0;
            end
            #1;
        end

        // ---- abort: calibration lost during beat 2 of an 8-beat write
        cyc(); #1;
        chk("ab_gnt", c0_gnt, 1'b1);
        chk("ab_en_b1", wr_en, 1'b1);
        cyc(); ddr3_init_done = 1'b0; #1;
        chk("ab_en_b2", wr_en, 1'b1);
        cyc(); #1;
        cyc(); #1;
        chk("ab_gnt_low", c0_gnt, 1'b0);
        chk("ab_wr_en_low", wr_en, 1'b0);
        chk("ab_pull_low", c0_pull, 1'b0);
        repeat (3) begin
            cyc(); #1;
            chk("ab_no_done", c0_done, 1'b0);
            chk("ab_no_gnt", c0_gnt, 1'b0);
            chk("ab_no_wr", wr_en, 1'b0);
        end

        // ---- re-init then a fresh c0 write of 2 beats
        cyc(); ddr3_init_done = 1'b1; c0_len = 10'd2;
        repeat (3) begin
            cyc(); #1;
            chk("reinit_gnt", c0_gnt, 1'b0);
        end
        cyc(); c0_req = 1'b0; #1;
        chk("reinit_gnt_on", c0_gnt, 1'b1);
        chk("reinit_wr_en", wr_en, 1'b1);
        chk("reinit_data", wr_data, 16'h0BB0);
        cyc(); #1;
        chk("reinit_wr_en2", wr_en, 1'b1);
        cyc(); #1;
        chk("reinit_done", c0_done, 1'b1);

        // ---- async reset in the middle of a c1 read
        cyc(); c1_req = 1'b1; c1_wr = 1'b0; c1_len = 10'd4; rd_empty = 1'b0; rd_data = 16'h0009; #1;
        cyc(); #1;
        chk("rr_rd_gnt", c1_gnt, 1'b1);
        chk("rr_rd_en", rd_en, 1'b1);
        cyc(); #1;
        chk("rr_rvalid", c1_rvalid, 1'b1);
        chk("rr_rdata", c1_rdata, 16'h0009);
        rst = 1'b1; #1;
        chk("arst_gnt", c1_gnt, 1'b0);
        chk("arst_rd_en", rd_en, 1'b0);
        chk("arst_rvalid", c1_rvalid, 1'b0);
        chk("arst_rdata", c1_rdata, 16'h0000);
        chk("arst_wr_data", wr_data, 16'h0000);
        chk("arst_done", c1_done, 1'b0);
        cyc(); rst = 1'b0;
        repeat (3) begin
            cyc(); #1;
            chk("post_rst_gnt", c1_gnt, 1'b0);
            chk("post_rst_rd_en", rd_en, 1'b0);
        end
        cyc(); #1;
        chk("post_rst_regnt", c1_gnt, 1'b1);
        chk("post_rst_rd", rd_en, 1'b1);
        c1_req = 1'b0; rd_empty = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ddr_port_arb.md
DDR_PORT_ARB -- requirements
Module: ddr_port_arb

Interface
REQ-001 SHALL have parameters: DW, default 16, data width; LW, default 10, burst-length width.
REQ-002 SHALL have port clk_50m  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ddr3_init_done  input  1  DDR3 calibration done, asynchronous to clk_50m.
REQ-005 SHALL have, per client k in {0,1}: ck_req in 1; ck_wr in 1 (1=write, 0=read); ck_len in LW (beats); ck_wdata in DW.
REQ-006 SHALL have, per client k: ck_gnt out 1; ck_pull out 1 (write beat taken); ck_rdata out DW; ck_rvalid out 1; ck_done out 1 (burst-complete pulse).
REQ-007 SHALL have DDR-port signals: wr_en out 1; wr_data out DW; wr_full in 1; rd_en out 1; rd_data in DW; rd_empty in 1.

Function
REQ-008 SHALL synchronise ddr3_init_done through two flops; "init" below means the synchronised value.
REQ-009 SHALL implement FSM states WAIT_INIT, IDLE, WRITE, READ, DRAIN, DONE; reset state WAIT_INIT.
REQ-010 WAIT_INIT -> IDLE when init is 1.
REQ-011 In IDLE, client k is eligible when ck_req=1 and ck_len!=0; ck_len=0 requests are ignored (no grant, no done).
REQ-012 Arbitration round-robin: both eligible -> client not granted last; reset value of last-granted = client 1 (client 0 wins first tie).
REQ-013 On grant, SHALL latch owner, ck_wr and ck_len, clear 10-bit beat counter, enter WRITE (ck_wr=1) or READ (ck_wr=0); ck_gnt rises the cycle after request was seen in IDLE.
REQ-014 ck_gnt SHALL be 1 only for the owner in WRITE, READ, DRAIN, DONE.
REQ-015 WRITE: each cycle with wr_full=0, wr_en=1, ck_pull=1 for owner, wr_data=owner's ck_wdata (combinational, same cycle), beat counter +1; wr_full=1 -> wr_en=0, no pull, counter held.
REQ-016 WRITE -> DONE on the cycle issuing beat number len (counter = len-1).
REQ-017 READ: each cycle with rd_empty=0, rd_en=1, counter +1; on beat number len -> DRAIN; rd_empty=1 stalls identically to REQ-015.
REQ-018 Read data SHALL be valid one cycle after rd_en: owner's ck_rdata<=rd_data and ck_rvalid=1 registered on the cycle after each rd_en; DRAIN lasts exactly one cycle to deliver the last beat, then -> DONE.
REQ-019 DONE: ck_done=1 for owner for exactly one cycle, update last-granted, -> IDLE; back-to-back bursts thus have one idle cycle between DONE and next grant.
REQ-020 Deassertion of ck_req, or change of ck_len/ck_wr, after grant SHALL NOT affect the burst in progress.
REQ-021 wr_en and rd_en SHALL never be 1 in the same cycle; wr_en/ck_pull only in WRITE, rd_en only in READ.
REQ-022 If init falls in any state other than WAIT_INIT, SHALL enter WAIT_INIT next cycle: gnt dropped, no done pulse, wr_en/rd_en 0 that cycle onward, pending rvalid for an issued rd_en still delivered.
REQ-023 wr_data SHALL be 0 when wr_en=0; ck_rdata holds its last value between rvalid pulses.
REQ-024 Burst length range 1..2^LW-1 beats; counter wrap not permitted.

Reset
REQ-025 On rst=1, asynchronously: state WAIT_INIT, sync flops 0, counter 0, last-granted = client 1, all ck_gnt/ck_pull/ck_rvalid/ck_done/wr_en/rd_en = 0, wr_data and ck_rdata = 0.
REQ-026 Reset asserted mid-burst SHALL abort without a done pulse; after release, the block waits for init again.

Verification
REQ-027 Init: rst released, ddr3_init_done rises at cycle 10 -> IDLE by cycle 12; no grant before.
REQ-028 Write: c0 req, wr=1, len=4, wdata=0x00A0..0x00A3, wr_full=0 -> wr_en 4 consecutive cycles with data A0..A3, c0_pull 4 cycles, c0_done one cycle later.
REQ-029 Read with stall: c1 req, wr=0, len=3, rd_empty high on 2nd beat cycle, rd_data = beat index -> rd_en 3 times over 4 cycles, c1_rvalid 3 times with 0,1,2, done after DRAIN.
REQ-030 Fairness: both clients request continuously, len=2 -> grants alternate 0,1,0,1; len=0 client never granted.
REQ-031 Abort: ddr3_init_done drops during c0 write beat 2 of 8 -> gnt and wr_en low within 3 cycles, no c0_done; re-init then new grant works.
REQ-032 Reset: rst pulse mid-READ -> all outputs 0 immediately, state WAIT_INIT.
